uart_wb_master: RTL and testbench
=================================

Name: uart_wb_master

Overview:
- Wishbone initiator that drives the UART register slave from the other end of its bus.
- Turns an upstream byte stream into TX-register writes, paced by the UART's tx-busy status.
- Reads the RX register whenever the slave flags new data, and presents received bytes on a downstream valid/ready stream.
- Sits between a host-side byte source/sink (or test harness) and the UART top.

Parameters:
- G_WORD_WIDTH, 8, width of data words on the bus and both streams.
- G_TX_ADDR, 1'b0, bus address of the TX register (write).
- G_RX_ADDR, 1'b1, bus address of the RX register (read).
- G_ACK_TIMEOUT, 255, cycles to wait for i_ack, or for i_tx_busy to rise, before aborting; must be >= 1.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_tx_valid  in  1  upstream byte valid.
- i_tx_data  in  G_WORD_WIDTH  upstream byte.
- o_tx_ready  out  1  upstream accept; transfer occurs when valid&&ready.
- o_rx_valid  out  1  downstream byte valid.
- o_rx_data  out  G_WORD_WIDTH  received byte.
- i_rx_ready  in  1  downstream accept.
- o_we  out  1  bus write enable.
- o_stb  out  1  bus strobe.
- o_addr  out  1  bus address.
- o_data  out  G_WORD_WIDTH  bus write data.
- i_ack  in  1  bus acknowledge (single-cycle pulse from slave).
- i_data  in  G_WORD_WIDTH  bus read data, valid with i_ack.
- i_tx_busy  in  1  UART transmitter busy.
- i_data_valid  in  1  slave pulse: new RX byte available.
- o_timeout  out  1  sticky: ack or busy-rise timeout occurred.
- o_overrun  out  1  sticky: i_data_valid seen while a read was already pending.

Behaviour:
- Reset (i_rst=1 at clock edge):
  - All outputs go to 0, FSM to IDLE, rx_pending to 0, timeout counter to 0.
  - Reset mid-transaction drops o_stb the next cycle; any in-flight byte is discarded.
- rx_pending flag:
  - Set by i_data_valid.
  - Cleared on the read ack cycle.
  - If i_data_valid coincides with the clear, the flag stays set.
  - If i_data_valid arrives while the flag is already set (and not clearing), the flag stays set and o_overrun is set.
- FSM states: IDLE, RD, RX_HOLD, WR, WAIT_BUSY.
- IDLE:
  - o_stb=0.
  - Priority 1: if rx_pending, go to RD.
  - Priority 2: else if i_tx_valid && !i_tx_busy, assert o_tx_ready combinationally this cycle, register i_tx_data into o_data, go to WR.
  - o_tx_ready is 1 only in this IDLE case.
- RD:
  - o_stb=1, o_we=0, o_addr=G_RX_ADDR.
  - On i_ack: o_rx_data<=i_data, o_rx_valid<=1, go to RX_HOLD.
- RX_HOLD:
  - o_stb=0; o_rx_valid and o_rx_data held stable.
  - On i_rx_ready: o_rx_valid<=0, go to IDLE.
- WR:
  - o_stb=1, o_we=1, o_addr=G_TX_ADDR, o_data stable.
  - On i_ack, go to WAIT_BUSY.
- WAIT_BUSY:
  - o_stb=0.
  - When i_tx_busy=1, go to IDLE. This guards against issuing a second write before busy has risen.
- Strobe timing:
  - o_stb is registered: it rises the cycle after entering RD/WR and falls the cycle after i_ack.
  - Minimum one cycle of o_stb=0 between consecutive transactions.
- Timeouts:
  - Counter cleared on every state entry; increments each cycle in RD, WR and WAIT_BUSY.
  - On reaching G_ACK_TIMEOUT: set o_timeout, go to IDLE.
  - RD timeout: rx_pending stays set, so the read is retried.
  - WR timeout: the byte is dropped.
  - WAIT_BUSY timeout: no data loss.
- Counter width is $clog2(G_ACK_TIMEOUT+1); no wrap is possible.
- i_ack is ignored outside RD/WR.
- Sticky flags clear only on reset.
- Latency: upstream accept to o_stb high = 1 cycle. Read ack to o_rx_valid high = 1 cycle.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [2:0] state_t {IDLE, RD, RX_HOLD, WR, WAIT_BUSY}.
  - Address localparams TX_ADDR=0 and RX_ADDR=1, reused by the slave register block.
- One natural sub-module: uart_wb_timeout, a loadable saturating counter with clear/enable/expired ports.
- Everything else stays in one module.

Test Plan:
- Write path: tx_valid=1, tx_data=0xA5, tx_busy=0, slave acks 2 cycles after stb.
  - o_tx_ready pulses once; o_stb=1, o_we=1, o_addr=0, o_data=0xA5 until ack.
  - FSM sits in WAIT_BUSY until tx_busy rises.
- Read path: data_valid pulse, slave returns 0x3C with ack.
  - Read with o_addr=1, o_we=0; o_rx_valid=1, o_rx_data=0x3C held 5 cycles while rx_ready=0, cleared the cycle after rx_ready=1.
- Priority: data_valid and tx_valid in the same cycle.
  - Read issued first, write of the pending byte after rx handshake.
  - o_tx_ready stays 0 until then.
- Overrun/simultaneous: second data_valid during RX_HOLD sets no overrun; a third before the read sets o_overrun=1.
  - data_valid coincident with read ack leaves rx_pending=1 and triggers another read.
- Timeout: slave never acks a write with G_ACK_TIMEOUT=4.
  - o_stb drops after 4 cycles, o_timeout=1 (sticky), FSM back in IDLE accepting the next byte.
- Reset mid-WR: i_rst while o_stb=1.
  - All outputs 0 the next cycle, no write retried, o_timeout/o_overrun cleared.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART Wishbone master and the UART register slave.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RX_HOLD,
        WR,
        WAIT_BUSY
    } state_t;

    // Register map of the UART slave, shared by both ends of the bus.
    localparam logic TX_ADDR = 1'b0;
    localparam logic RX_ADDR = 1'b1;

endpackage

// File: rtl/uart_wb_timeout.sv
// Saturating cycle counter used to bound bus acks and the tx-busy rise.
// o_expired flags the cycle in which the G_LIMIT-th enabled cycle is being spent,
// so a state that enables the counter can leave after exactly G_LIMIT cycles.
module uart_wb_timeout #(
    parameter int G_LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = $clog2(G_LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(G_LIMIT - 1);
    localparam logic [W-1:0] SAT  = W'(G_LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise count up and stick at the limit.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != SAT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Independent of i_enable so the user's next-state logic forms no loop.
    assign o_expired = (count_q >= LAST);

endmodule

// File: rtl/uart_wb_master.sv
// Wishbone initiator for the UART register slave: upstream bytes become TX
// register writes paced by tx-busy, and flagged RX bytes are read and offered
// on a downstream valid/ready stream.
module uart_wb_master
    import uart_pkg::*;
#(
    parameter int   G_WORD_WIDTH  = 8,
    parameter logic G_TX_ADDR     = TX_ADDR,
    parameter logic G_RX_ADDR     = RX_ADDR,
    parameter int   G_ACK_TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_tx_valid,
    input  logic [G_WORD_WIDTH-1:0] i_tx_data,
    output logic                    o_tx_ready,
    output logic                    o_rx_valid,
    output logic [G_WORD_WIDTH-1:0] o_rx_data,
    input  logic                    i_rx_ready,
    output logic                    o_we,
    output logic                    o_stb,
    output logic                    o_addr,
    output logic [G_WORD_WIDTH-1:0] o_data,
    input  logic                    i_ack,
    input  logic [G_WORD_WIDTH-1:0] i_data,
    input  logic                    i_tx_busy,
    input  logic                    i_data_valid,
    output logic                    o_timeout,
    output logic                    o_overrun
);

    state_t state_q, state_d;

    logic                    rx_pend_q, rx_pend_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic                    addr_q, addr_d;
    logic [G_WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [G_WORD_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    timeout_q, timeout_d;
    logic                    overrun_q, overrun_d;

    logic tx_accept;
    logic rd_ack;
    logic pend_now;
    logic cnt_clear;
    logic cnt_en;
    logic cnt_expired;

    uart_wb_timeout #(
        .G_LIMIT (G_ACK_TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (cnt_clear),
        .i_enable  (cnt_en),
        .o_expired (cnt_expired)
    );

    // Next-state, pending/sticky flags and registered bus outputs.
    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        timeout_d  = timeout_q;
        tx_accept  = 1'b0;
        cnt_en     = 1'b0;

        rd_ack   = (state_q == RD) && i_ack;
        // A pulse arriving while idle already counts, so reads beat a
        // simultaneous upstream byte.
        pend_now = rx_pend_q || i_data_valid;

        case (state_q)
            IDLE: begin
                if (pend_now) begin
                    state_d = RD;
                end else if (i_tx_valid && !i_tx_busy) begin
                    tx_accept = 1'b1;
                    wdata_d   = i_tx_data;
                    state_d   = WR;
                end
            end
            RD: begin
                cnt_en = 1'b1;
                if (i_ack) begin
                    rx_data_d  = i_data;
                    rx_valid_d = 1'b1;
                    state_d    = RX_HOLD;
                end else if (cnt_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            RX_HOLD: begin
                if (i_rx_ready) begin
                    rx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            WR: begin
                cnt_en = 1'b1;
                if (i_ack) begin
                    state_d = WAIT_BUSY;
                end else if (cnt_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_BUSY: begin
                cnt_en = 1'b1;
                if (i_tx_busy) begin
                    state_d = IDLE;
                end else if (cnt_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A read timeout leaves the flag set, so the read is retried.
        rx_pend_d = i_data_valid || (rx_pend_q && !rd_ack);
        overrun_d = overrun_q || (i_data_valid && rx_pend_q && !rd_ack);

        // Strobe and qualifiers follow the state being entered.
        stb_d  = (state_d == RD) || (state_d == WR);
        we_d   = (state_d == WR);
        addr_d = (state_d == RD) ? G_RX_ADDR :
                 (state_d == WR) ? G_TX_ADDR : 1'b0;

        cnt_clear = (state_d != state_q);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            rx_pend_q  <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 1'b0;
            wdata_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_pend_q  <= rx_pend_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    // No byte is taken while reset is asserted; it would be discarded anyway.
    assign o_tx_ready = tx_accept && !i_rst;
    assign o_rx_valid = rx_valid_q;
    assign o_rx_data  = rx_data_q;
    assign o_we       = we_q;
    assign o_stb      = stb_q;
    assign o_addr     = addr_q;
    assign o_data     = wdata_q;
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: directed scenarios with literal expectations, then
// randomized slave/stream behaviour checked every cycle against a
// transaction-level model of the master.
module tb_uart_wb_master;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       txv;
    logic [7:0] txd;
    logic       tx_ready;
    logic       rxv;
    logic [7:0] rxd;
    logic       rxr;
    logic       we;
    logic       stb;
    logic       addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;
    logic       busy;
    logic       dv;
    logic       to;
    logic       ov;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_wb_master #(
        .G_WORD_WIDTH  (8),
        .G_TX_ADDR     (1'b0),
        .G_RX_ADDR     (1'b1),
        .G_ACK_TIMEOUT (TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tx_valid   (txv),
        .i_tx_data    (txd),
        .o_tx_ready   (tx_ready),
        .o_rx_valid   (rxv),
        .o_rx_data    (rxd),
        .i_rx_ready   (rxr),
        .o_we         (we),
        .o_stb        (stb),
        .o_addr       (addr),
        .o_data       (wdata),
        .i_ack        (ack),
        .i_data       (rdata),
        .i_tx_busy    (busy),
        .i_data_valid (dv),
        .o_timeout    (to),
        .o_overrun    (ov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------
    // Transaction-level model: what the master is doing right now.
    // ---------------------------------------------------------------
    localparam int DOING_NOTHING  = 0;
    localparam int READING        = 1;
    localparam int OFFERING_BYTE  = 2;
    localparam int WRITING        = 3;
    localparam int AWAITING_BUSY  = 4;

    bit       m_valid = 0;
    int       m_doing;
    int       m_age;      // cycles already spent in the current activity
    bit       m_pend;     // an RX byte is announced and not yet read
    logic [7:0] m_wd;
    bit       m_rxv;
    logic [7:0] m_rxd;
    bit       m_to;
    bit       m_ov;

    // Compare DUT outputs with the model, then advance the model by one cycle.
    always @(negedge clk) begin : model
        bit announced;
        bit read_done;
        bit give_up;
        bit exp_ready;
        int next_doing;

        announced = m_pend || dv;
        exp_ready = (m_doing == DOING_NOTHING) && !announced && txv && !busy && !rst;

        if (m_valid) begin
            chk("m_tx_ready", 32'(tx_ready), 32'(exp_ready));
            chk("m_stb", 32'(stb), 32'((m_doing == READING) || (m_doing == WRITING)));
            chk("m_we", 32'(we), 32'(m_doing == WRITING));
            chk("m_addr", 32'(addr), 32'(m_doing == READING));
            chk("m_data", 32'(wdata), 32'(m_wd));
            chk("m_rx_valid", 32'(rxv), 32'(m_rxv));
            chk("m_rx_data", 32'(rxd), 32'(m_rxd));
            chk("m_timeout", 32'(to), 32'(m_to));
            chk("m_overrun", 32'(ov), 32'(m_ov));
        end

        if (rst) begin
            m_valid = 1;
            m_doing = DOING_NOTHING;
            m_age   = 0;
            m_pend  = 0;
            m_wd    = 8'h00;
            m_rxv   = 0;
            m_rxd   = 8'h00;
            m_to    = 0;
            m_ov    = 0;
        end else if (m_valid) begin
            read_done  = (m_doing == READING) && ack;
            give_up    = (m_age + 1 >= TMO);
            next_doing = m_doing;

            if (dv && m_pend && !read_done) m_ov = 1;
            m_pend = dv || (m_pend && !read_done);

            if (m_doing == DOING_NOTHING) begin
                if (announced) next_doing = READING;
                else if (txv && !busy) begin
                    m_wd = txd;
                    next_doing = WRITING;
                end
            end else if (m_doing == READING) begin
                if (ack) begin
                    m_rxd = rdata;
                    m_rxv = 1;
                    next_doing = OFFERING_BYTE;
                end else if (give_up) begin
                    m_to = 1;
                    next_doing = DOING_NOTHING;
                end
            end else if (m_doing == OFFERING_BYTE) begin
                if (rxr) begin
                    m_rxv = 0;
                    next_doing = DOING_NOTHING;
                end
            end else if (m_doing == WRITING) begin
                if (ack) next_doing = AWAITING_BUSY;
                else if (give_up) begin
                    m_to = 1;
                    next_doing = DOING_NOTHING;
                end
            end else begin
                if (busy) next_doing = DOING_NOTHING;
                else if (give_up) begin
                    m_to = 1;
                    next_doing = DOING_NOTHING;
                end
            end

            m_age   = (next_doing == m_doing) ? m_age + 1 : 0;
            m_doing = next_doing;
        end
    end

    // ---------------------------------------------------------------
    // Stimulus: directed scenarios, then randomized traffic.
    // ---------------------------------------------------------------
    int bdel = 0;
    int blen = 0;

    initial begin
        rst = 1; txv = 0; txd = 0; rxr = 0; ack = 0; rdata = 0; busy = 0; dv = 0;
        tick();
        tick();
        chk("rst_stb", 32'(stb), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_data", 32'(wdata), 0);
        chk("rst_rx_valid", 32'(rxv), 0);
        chk("rst_rx_data", 32'(rxd), 0);
        chk("rst_timeout", 32'(to), 0);
        chk("rst_overrun", 32'(ov), 0);
        rst = 0;
        tick();

        // Write path, ack two cycles after strobe.
        txv = 1; txd = 8'hA5;
        #1 chk("wr_ready", 32'(tx_ready), 1);
        tick();
        txv = 0;
        chk("wr_stb", 32'(stb), 1);
        chk("wr_we", 32'(we), 1);
        chk("wr_addr", 32'(addr), 0);
        chk("wr_data", 32'(wdata), 32'h0A5);
        tick();
        chk("wr_stb_c1", 32'(stb), 1);
        tick();
        chk("wr_stb_c2", 32'(stb), 1);
        ack = 1;
        tick();
        ack = 0;
        chk("wr_stb_fall", 32'(stb), 0);
        txv = 1; txd = 8'h11;
        #1 chk("wait_busy_block", 32'(tx_ready), 0);
        txv = 0;
        tick();
        chk("wait_busy_stb", 32'(stb), 0);
        busy = 1;
        tick();
        busy = 0;

        // Read path with a stalled downstream consumer.
        dv = 1;
        tick();
        dv = 0;
        chk("rd_stb", 32'(stb), 1);
        chk("rd_we", 32'(we), 0);
        chk("rd_addr", 32'(addr), 1);
        ack = 1; rdata = 8'h3C;
        tick();
        ack = 0;
        chk("rd_rx_valid", 32'(rxv), 1);
        chk("rd_rx_data", 32'(rxd), 32'h03C);
        chk("rd_stb_fall", 32'(stb), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rd_hold_valid", 32'(rxv), 1);
            chk("rd_hold_data", 32'(rxd), 32'h03C);
        end
        rxr = 1;
        tick();
        rxr = 0;
        chk("rd_valid_clear", 32'(rxv), 0);

        // Read wins over a simultaneous upstream byte.
        dv = 1; txv = 1; txd = 8'h5A;
        #1 chk("pri_ready_idle", 32'(tx_ready), 0);
        tick();
        dv = 0;
        chk("pri_read_first", 32'(we), 0);
        chk("pri_read_stb", 32'(stb), 1);
        chk("pri_ready_rd", 32'(tx_ready), 0);
        ack = 1; rdata = 8'h77;
        tick();
        ack = 0;
        chk("pri_ready_hold", 32'(tx_ready), 0);
        rxr = 1;
        tick();
        rxr = 0;
        chk("pri_ready_after", 32'(tx_ready), 1);
        tick();
        txv = 0;
        chk("pri_wr_we", 32'(we), 1);
        chk("pri_wr_data", 32'(wdata), 32'h05A);
        ack = 1;
        tick();
        ack = 0; busy = 1;
        tick();
        busy = 0;

        // Overrun and data_valid coincident with the read ack.
        dv = 1;
        tick();
        dv = 0;
        ack = 1; rdata = 8'h01;
        tick();
        ack = 0;
        dv = 1;
        tick();
        dv = 0;
        chk("ov_second_none", 32'(ov), 0);
        dv = 1;
        tick();
        dv = 0;
        chk("ov_third_set", 32'(ov), 1);
        rxr = 1;
        tick();
        rxr = 0;
        tick();
        chk("ov_retry_stb", 32'(stb), 1);
        chk("ov_retry_we", 32'(we), 0);
        ack = 1; rdata = 8'h02; dv = 1;
        tick();
        ack = 0; dv = 0;
        chk("ov_coinc_data", 32'(rxd), 32'h002);
        rxr = 1;
        tick();
        rxr = 0;
        tick();
        chk("ov_reread_stb", 32'(stb), 1);
        chk("ov_reread_we", 32'(we), 0);
        ack = 1; rdata = 8'h03;
        tick();
        ack = 0; rxr = 1;
        tick();
        rxr = 0;

        // Write never acknowledged: gives up after TMO strobe cycles.
        chk("to_before", 32'(to), 0);
        txv = 1; txd = 8'hC3;
        tick();
        txv = 0;
        for (int i = 0; i < TMO; i++) begin
            chk("to_stb_high", 32'(stb), 1);
            tick();
        end
        chk("to_stb_drop", 32'(stb), 0);
        chk("to_flag", 32'(to), 1);
        txv = 1; txd = 8'h99;
        #1 chk("to_next_ready", 32'(tx_ready), 1);
        tick();
        txv = 0;
        chk("to_next_stb", 32'(stb), 1);
        chk("to_next_data", 32'(wdata), 32'h099);

        // Reset in the middle of that write.
        rst = 1;
        tick();
        rst = 0;
        chk("rstmid_stb", 32'(stb), 0);
        chk("rstmid_we", 32'(we), 0);
        chk("rstmid_data", 32'(wdata), 0);
        chk("rstmid_timeout", 32'(to), 0);
        chk("rstmid_overrun", 32'(ov), 0);
        tick();
        tick();
        chk("rstmid_no_retry", 32'(stb), 0);

        // Randomized slave, upstream source and downstream sink.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 399) == 0);
            ack   = stb ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
            rdata = 8'($urandom);
            txv   = ($urandom_range(0, 9) < 6);
            txd   = 8'($urandom);
            dv    = ($urandom_range(0, 11) == 0);
            rxr   = ($urandom_range(0, 1) == 1);
            if (stb && we && ack) bdel = $urandom_range(1, 6);
            if (blen > 0) begin
                blen--;
            end else if (bdel > 0) begin
                bdel--;
                if (bdel == 0) blen = $urandom_range(2, 8);
            end else if ($urandom_range(0, 29) == 0) begin
                blen = $urandom_range(1, 3);
            end
            busy = (blen > 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
